// File: rtl/r4i_operand_issue_if.sv
// Handshake bundle between instruction buffer, R4 operand issue block and R4 ALU.
// master: the issue block; slave: its surroundings (buffer + ALU).
interface r4i_operand_issue_if #(
    parameter int REG_WIDTH   = 128,
    parameter int ADDR_WIDTH  = 5,
    parameter int INSTR_WIDTH = 25,
    parameter int CTRL_WIDTH  = 2
) ();
    logic                   in_valid;
    logic                   in_ready;
    logic [INSTR_WIDTH-1:0] in_instr;
    logic                   out_valid;
    logic                   out_ready;
    logic [CTRL_WIDTH-1:0]  out_ctrl;
    logic [ADDR_WIDTH-1:0]  out_rd;
    logic [REG_WIDTH-1:0]   out_rs1;
    logic [REG_WIDTH-1:0]   out_rs2;
    logic [REG_WIDTH-1:0]   out_rs3;

    modport master (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_ctrl, out_rd,
        output out_rs1, out_rs2, out_rs3
    );

    modport slave (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_ctrl, out_rd,
        input  out_rs1, out_rs2, out_rs3
    );
endinterface

// File: rtl/r4i_operand_issue.sv
// R4 operand issue: fetch three sources over one RF read port, then hand off to the ALU.
// Optional R4I_ZERO_REG_EN: source index 0 reads as zero.
module r4i_operand_issue #(
    parameter int REG_WIDTH   = 128,
    parameter int ADDR_WIDTH  = 5,
    parameter int INSTR_WIDTH = 25,
    parameter int CTRL_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    r4i_operand_issue_if.master   io,
    output logic                  rf_ren,
    output logic [ADDR_WIDTH-1:0] rf_raddr,
    input  logic [REG_WIDTH-1:0]  rf_rdata,
    output logic                  err_illegal
);
    typedef enum logic [2:0] {
        S_IDLE, S_RD1, S_RD2, S_RD3, S_CAP, S_ISSUE
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rs2_q, rs2_d;
    logic [ADDR_WIDTH-1:0] rs3_q, rs3_d;
    logic [ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
    logic [REG_WIDTH-1:0]  rs1v_q, rs1v_d;
    logic [REG_WIDTH-1:0]  rs2v_q, rs2v_d;
    logic [REG_WIDTH-1:0]  rs3v_q, rs3v_d;
    logic                  valid_q, valid_d;
    logic                  ren_q, ren_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic                  err_q, err_d;
    logic [REG_WIDTH-1:0]  cap_data;
    logic                  accept;
    logic                  legal;

    logic [1:0] f_fmt;
    logic [2:0] f_op;
    logic [4:0] f_rs3, f_rs2, f_rs1, f_rd;

    assign f_fmt = io.in_instr[24:23];
    assign f_op  = io.in_instr[22:20];
    assign f_rs3 = io.in_instr[19:15];
    assign f_rs2 = io.in_instr[14:10];
    assign f_rs1 = io.in_instr[9:5];
    assign f_rd  = io.in_instr[4:0];

    assign legal       = (f_fmt == 2'b10) && !f_op[2];
    assign io.in_ready = (state_q == S_IDLE) && !rst;
    assign accept      = io.in_valid && io.in_ready;

`ifdef R4I_ZERO_REG_EN
    // Remembers whether the index read last cycle was 0; its data arrives now.
    logic src_zero_q, src_zero_d;
    assign src_zero_d = (raddr_q == '0);
    assign cap_data   = src_zero_q ? '0 : rf_rdata;

    always_ff @(posedge clk) begin
        if (rst) src_zero_q <= 1'b0;
        else     src_zero_q <= src_zero_d;
    end
`else
    assign cap_data = rf_rdata;
`endif

    always_comb begin
        state_d = state_q;
        rs2_d   = rs2_q;
        rs3_d   = rs3_q;
        rd_d    = rd_q;
        ctrl_d  = ctrl_q;
        rs1v_d  = rs1v_q;
        rs2v_d  = rs2v_q;
        rs3v_d  = rs3v_q;
        valid_d = valid_q;
        ren_d   = ren_q;
        raddr_d = raddr_q;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept && legal) begin
                    rs2_d   = f_rs2;
                    rs3_d   = f_rs3;
                    rd_d    = f_rd;
                    ctrl_d  = f_op[1:0];
                    ren_d   = 1'b1;
                    raddr_d = f_rs1;
                    state_d = S_RD1;
                end else if (accept) begin
                    err_d = 1'b1;
                end
            end
            S_RD1: begin
                raddr_d = rs2_q;
                state_d = S_RD2;
            end
            S_RD2: begin
                rs1v_d  = cap_data;
                raddr_d = rs3_q;
                state_d = S_RD3;
            end
            S_RD3: begin
                rs2v_d  = cap_data;
                ren_d   = 1'b0;
                state_d = S_CAP;
            end
            S_CAP: begin
                rs3v_d  = cap_data;
                valid_d = 1'b1;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (io.out_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rs2_q   <= '0;
            rs3_q   <= '0;
            rd_q    <= '0;
            ctrl_q  <= '0;
            rs1v_q  <= '0;
            rs2v_q  <= '0;
            rs3v_q  <= '0;
            valid_q <= 1'b0;
            ren_q   <= 1'b0;
            raddr_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rs2_q   <= rs2_d;
            rs3_q   <= rs3_d;
            rd_q    <= rd_d;
            ctrl_q  <= ctrl_d;
            rs1v_q  <= rs1v_d;
            rs2v_q  <= rs2v_d;
            rs3v_q  <= rs3v_d;
            valid_q <= valid_d;
            ren_q   <= ren_d;
            raddr_q <= raddr_d;
            err_q   <= err_d;
        end
    end

    assign io.out_valid = valid_q;
    assign io.out_ctrl  = ctrl_q;
    assign io.out_rd    = rd_q;
    assign io.out_rs1   = rs1v_q;
    assign io.out_rs2   = rs2v_q;
    assign io.out_rs3   = rs3v_q;
    assign rf_ren       = ren_q;
    assign rf_raddr     = raddr_q;
    assign err_illegal  = err_q;
endmodule

// File: tb/tb_r4i_operand_issue.sv
// Directed-vector bench for r4i_operand_issue with a behavioural register file.
// Honours R4I_ZERO_REG_EN when the bundle is compiled with it.
module tb_r4i_operand_issue;
    localparam int RW = 128;
    localparam int AW = 5;
    localparam int IW = 25;
    localparam int CW = 2;
    localparam logic [RW-1:0] ONES = '1;
`ifdef R4I_ZERO_REG_EN
    localparam logic [RW-1:0] ZSRC = '0;
`else
    localparam logic [RW-1:0] ZSRC = ONES;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          rf_ren;
    logic [AW-1:0] rf_raddr;
    logic [RW-1:0] rf_rdata;
    logic          err_illegal;
    logic [RW-1:0] rf [32];

    int n_pass = 0;
    int n_tot  = 0;

    r4i_operand_issue_if #(RW, AW, IW, CW) bus ();

    r4i_operand_issue #(
        .REG_WIDTH(RW), .ADDR_WIDTH(AW),
        .INSTR_WIDTH(IW), .CTRL_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io(bus),
        .rf_ren(rf_ren),
        .rf_raddr(rf_raddr),
        .rf_rdata(rf_rdata),
        .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    // Read data valid one cycle after the enable; garbage otherwise.
    always @(posedge clk)
        rf_rdata <= rf_ren ? rf[rf_raddr] : {4{32'hdeadbeef}};

    typedef struct {
        logic [1:0] fmt;
        logic [2:0] op;
        logic [4:0] rs3;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [4:0] rd;
        int         stall;
        logic       ill;
        logic [1:0] ctrl;
        logic [RW-1:0] e1;
        logic [RW-1:0] e2;
        logic [RW-1:0] e3;
    } vec_t;

    vec_t v [7];

    task automatic chk(input string name, input logic [RW-1:0] act,
                       input logic [RW-1:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic run_vec(input vec_t t, input int k);
        string p;
        logic [CW-1:0] c0;
        logic [RW-1:0] r1;
        p = $sformatf("v%0d", k);
        @(negedge clk);
        bus.in_instr  = {t.fmt, t.op, t.rs3, t.rs2, t.rs1, t.rd};
        bus.in_valid  = 1'b1;
        bus.out_ready = (t.stall == 0);
        #1 chk({p, " in_ready_idle"}, bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_instr = '1;
        if (t.ill) begin
            chk({p, " err"}, err_illegal, 1'b1);
            chk({p, " ren"}, rf_ren, 1'b0);
            chk({p, " valid"}, bus.out_valid, 1'b0);
            chk({p, " in_ready"}, bus.in_ready, 1'b1);
            @(posedge clk);
            #1;
            chk({p, " err_clr"}, err_illegal, 1'b0);
            chk({p, " ren2"}, rf_ren, 1'b0);
            chk({p, " valid2"}, bus.out_valid, 1'b0);
        end else begin
            chk({p, " ren1"}, rf_ren, 1'b1);
            chk({p, " raddr1"}, rf_raddr, t.rs1);
            chk({p, " busy"}, bus.in_ready, 1'b0);
            chk({p, " no_err"}, err_illegal, 1'b0);
            @(posedge clk);
            #1;
            chk({p, " ren2"}, rf_ren, 1'b1);
            chk({p, " raddr2"}, rf_raddr, t.rs2);
            @(posedge clk);
            #1;
            chk({p, " ren3"}, rf_ren, 1'b1);
            chk({p, " raddr3"}, rf_raddr, t.rs3);
            @(posedge clk);
            #1;
            chk({p, " ren_off"}, rf_ren, 1'b0);
            chk({p, " valid_cap"}, bus.out_valid, 1'b0);
            @(posedge clk);
            #1;
            chk({p, " valid"}, bus.out_valid, 1'b1);
            chk({p, " ctrl"}, bus.out_ctrl, t.ctrl);
            chk({p, " rd"}, bus.out_rd, t.rd);
            chk({p, " rs1"}, bus.out_rs1, t.e1);
            chk({p, " rs2"}, bus.out_rs2, t.e2);
            chk({p, " rs3"}, bus.out_rs3, t.e3);
            c0 = t.ctrl;
            r1 = t.e1;
            for (int i = 0; i < t.stall; i++) begin
                @(posedge clk);
                #1;
                chk({p, " hold_valid"}, bus.out_valid, 1'b1);
                chk({p, " hold_ctrl"}, bus.out_ctrl, c0);
                chk({p, " hold_rs1"}, bus.out_rs1, r1);
                chk({p, " hold_rs3"}, bus.out_rs3, t.e3);
                chk({p, " hold_busy"}, bus.in_ready, 1'b0);
            end
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            chk({p, " drop_valid"}, bus.out_valid, 1'b0);
            chk({p, " back_idle"}, bus.in_ready, 1'b1);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = {4{32'(i)}};
        rf[0] = ONES;

        v[0] = '{2'b10, 3'b010, 5'd3, 5'd2, 5'd1, 5'd7, 0, 1'b0, 2'b10,
                 {4{32'd1}}, {4{32'd2}}, {4{32'd3}}};
        v[1] = '{2'b10, 3'b010, 5'd3, 5'd2, 5'd1, 5'd7, 5, 1'b0, 2'b10,
                 {4{32'd1}}, {4{32'd2}}, {4{32'd3}}};
        v[2] = '{2'b11, 3'b010, 5'd3, 5'd2, 5'd1, 5'd7, 0, 1'b1, 2'b00,
                 '0, '0, '0};
        v[3] = '{2'b10, 3'b100, 5'd3, 5'd2, 5'd1, 5'd7, 0, 1'b1, 2'b00,
                 '0, '0, '0};
        v[4] = '{2'b10, 3'b001, 5'd5, 5'd5, 5'd5, 5'd31, 0, 1'b0, 2'b01,
                 {4{32'd5}}, {4{32'd5}}, {4{32'd5}}};
        v[5] = '{2'b10, 3'b011, 5'd31, 5'd9, 5'd0, 5'd0, 2, 1'b0, 2'b11,
                 ZSRC, {4{32'd9}}, {4{32'd31}}};
        v[6] = '{2'b01, 3'b000, 5'd4, 5'd4, 5'd4, 5'd4, 0, 1'b1, 2'b00,
                 '0, '0, '0};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst in_ready", bus.in_ready, 1'b0);
        chk("rst ren", rf_ren, 1'b0);
        chk("rst raddr", rf_raddr, '0);
        chk("rst valid", bus.out_valid, 1'b0);
        chk("rst err", err_illegal, 1'b0);
        chk("rst ctrl", bus.out_ctrl, '0);
        chk("rst rd", bus.out_rd, '0);
        chk("rst rs1", bus.out_rs1, '0);
        chk("rst rs2", bus.out_rs2, '0);
        chk("rst rs3", bus.out_rs3, '0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("post_rst in_ready", bus.in_ready, 1'b1);

        for (int k = 0; k < 7; k++) run_vec(v[k], k);

        // Reset during RD3 aborts the fetch.
        @(negedge clk);
        bus.in_instr  = {2'b10, 3'b000, 5'd6, 5'd8, 5'd10, 5'd12};
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("abort in_rd3_ren", rf_ren, 1'b1);
        chk("abort in_rd3_raddr", rf_raddr, 5'd6);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort ren", rf_ren, 1'b0);
        chk("abort valid", bus.out_valid, 1'b0);
        chk("abort in_ready_rst", bus.in_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("abort idle", bus.in_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("abort quiet_valid", bus.out_valid, 1'b0);
            chk("abort quiet_err", err_illegal, 1'b0);
        end
        run_vec(v[0], 7);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
